// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers one request onto the ALU pins, waits for the
// result to settle, then holds result/cout/zero/err/tag on a valid/ready port.
//
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   req_valid/req_ready              - request handshake
//   req_a, req_b, req_cin, req_op    - operation for the ALU
//   req_tag                          - requester tag, echoed on the response
//   alu_a, alu_b, alu_cin, alu_op    - registered ALU inputs
//   alu_result, alu_cout             - combinational ALU outputs
//   rsp_valid/rsp_ready              - response handshake
//   rsp_result, rsp_cout, rsp_zero   - captured ALU outputs
//   rsp_err, rsp_tag                 - illegal-opcode flag, echoed tag
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_cin,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter counts down to zero, so a load of N-1 gives N settle cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic               alu_cin_q, alu_cin_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               op_legal;

    always_comb begin
        op_legal = 1'b0;
        unique case (req_op)
            3'b000, 3'b001, 3'b010,
            3'b110, 3'b111: op_legal = 1'b1;
            default:        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_tag_d = req_tag;
                    if (op_legal) begin
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_cin_d = req_cin;
                        alu_op_d  = req_op;
                        cnt_d     = CNT_LOAD;
                        state_d   = SETTLE;
                    end else begin
                        // Illegal op never reaches the ALU pins.
                        rsp_result_d = '0;
                        rsp_cout_d   = 1'b0;
                        rsp_zero_d   = 1'b0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_cout_d   = alu_cout;
                    rsp_zero_d   = (alu_result == 32'd0);
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test of alu_issue_ctrl driving a
// behavioural 32-bit ALU, SETTLE_CYCLES = 2.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_cin;
    logic [2:0]  req_op;
    logic [3:0]  req_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_err;
    logic [3:0]  rsp_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .SETTLE_CYCLES(2),
        .TAG_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_cin(req_cin),
        .req_op(req_op),
        .req_tag(req_tag),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_cin(alu_cin),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_cout(alu_cout),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_cout(rsp_cout),
        .rsp_zero(rsp_zero),
        .rsp_err(rsp_err),
        .rsp_tag(rsp_tag)
    );

    // Behavioural stand-in for the team ALU.
    always_comb begin
        logic [32:0] sum;
        sum        = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                alu_result = sum[31:0];
                alu_cout   = sum[32];
            end
            3'b110: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = sum[31:0];
                alu_cout   = sum[32];
            end
            3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; the edge is the handshake.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [2:0] op,
                         input logic [3:0] tag);
        chk("pre_req_ready", {31'd0, req_ready}, 32'd1);
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("retire_valid", {31'd0, rsp_valid}, 32'd0);
        chk("retire_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Legal op: valid must appear on the third edge counted from handshake.
    task automatic run_op(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] tag, input logic [31:0] e_res,
                          input logic e_cout, input logic e_zero);
        issue(a, b, 1'b0, op, tag);
        chk({name, "_lat1"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({name, "_lat2"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_result"}, rsp_result, e_res);
        chk({name, "_cout"}, {31'd0, rsp_cout}, {31'd0, e_cout});
        chk({name, "_zero"}, {31'd0, rsp_zero}, {31'd0, e_zero});
        chk({name, "_err"}, {31'd0, rsp_err}, 32'd0);
        chk({name, "_tag"}, {28'd0, rsp_tag}, {28'd0, tag});
        retire();
    endtask

    initial begin
        logic [31:0] held_res;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_op    = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // ADD 5 + 3
        run_op("add", 32'h0000_0005, 32'h0000_0003, 3'b010, 4'h3,
               32'h0000_0008, 1'b0, 1'b0);

        // AND with operand stability during settle
        issue(32'hED5A_B56A, 32'h5EFD_FBF7, 1'b0, 3'b000, 4'h1);
        req_a = 32'h1234_5678;
        req_b = 32'h8765_4321;
        chk("and_a0", alu_a, 32'hED5A_B56A);
        chk("and_b0", alu_b, 32'h5EFD_FBF7);
        tick();
        chk("and_a1", alu_a, 32'hED5A_B56A);
        chk("and_b1", alu_b, 32'h5EFD_FBF7);
        tick();
        chk("and_valid", {31'd0, rsp_valid}, 32'd1);
        chk("and_result", rsp_result, 32'h4C58_B162);
        chk("and_zero", {31'd0, rsp_zero}, 32'd0);
        retire();

        // SUB equal operands, then signed SLT
        run_op("sub", 32'h2A2A_2A2A, 32'h2A2A_2A2A, 3'b110, 4'h4,
               32'h0000_0000, 1'b1, 1'b1);
        run_op("slt", 32'hA000_0000, 32'hB000_0000, 3'b111, 4'h6,
               32'h0000_0001, 1'b0, 1'b0);

        // Illegal opcode: latency 1, alu_op untouched
        issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 3'b011, 4'h9);
        chk("ill_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill_err", {31'd0, rsp_err}, 32'd1);
        chk("ill_result", rsp_result, 32'd0);
        chk("ill_zero", {31'd0, rsp_zero}, 32'd0);
        chk("ill_tag", {28'd0, rsp_tag}, 32'h9);
        chk("ill_alu_op", {29'd0, alu_op}, 32'h7);
        chk("ill_alu_a", alu_a, 32'hA000_0000);
        retire();

        // Backpressure: OR result held for 5 cycles, new request refused
        issue(32'hF0F0_0000, 32'h0000_000F, 1'b0, 3'b001, 4'hA);
        tick();
        tick();
        chk("bp_valid0", {31'd0, rsp_valid}, 32'd1);
        held_res  = rsp_result;
        chk("bp_result0", held_res, 32'hF0F0_000F);
        req_a     = 32'h5555_5555;
        req_op    = 3'b010;
        req_tag   = 4'hB;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'hF0F0_000F);
            chk("bp_tag", {28'd0, rsp_tag}, 32'hA);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        // req_valid still high on the retire edge: must not be taken
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_ret_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_ret_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_ret_alu_a", alu_a, 32'hF0F0_0000);
        chk("bp_ret_keep", rsp_result, 32'hF0F0_000F);

        // Reset during SETTLE discards the op
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 3'b010, 4'h5);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_tag", {28'd0, rsp_tag}, 32'd0);
        tick();
        tick();
        chk("mid_rst_novalid", {31'd0, rsp_valid}, 32'd0);

        run_op("addc", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 4'h2,
               32'h0000_0000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
